document_parser_ctrl: RTL

- Top-level sequencer for the XML/HTML character stream.
- Watches content characters, detects `<`, and enables `element_parser` for exactly one tag, starting on the character after `<`.
- Collects the parser's tag/closing result and maintains a tag-nesting stack.
- Emits open/close/text events and sticky error status to the layout stage.

---
 rtl/document_parser_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/document_parser_ctrl.sv
// Stream sequencer: hands each <...> tag to element_parser, keeps the nesting stack, emits open/close/text events.
// Build option DOC_TAG_MATCH_CHECK_EN: closing tags are compared with the stack top (error code 3 on mismatch).
module document_parser_ctrl #(
   parameter int CHAR_W      = 8,
   parameter int TAG_W       = 4,
   parameter int DEPTH       = 8,
   parameter int FIN_TIMEOUT = 15
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [CHAR_W-1:0]            char,
   input  logic                         char_valid,
   output logic                         char_ready,
   output logic [CHAR_W-1:0]            elem_char,
   output logic                         elem_enable,
   input  logic                         elem_finished,
   input  logic [TAG_W-1:0]             elem_tag,
   input  logic                         elem_closing,
   output logic                         event_valid,
   output logic                         event_close,
   output logic [TAG_W-1:0]             event_tag,
   output logic                         text_valid,
   output logic [CHAR_W-1:0]            text_char,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         doc_done,
   output logic                         error,
   output logic [2:0]                   error_code
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(FIN_TIMEOUT + 1);

   localparam logic [CHAR_W-1:0] CH_LT = CHAR_W'(60);
   localparam logic [CHAR_W-1:0] CH_GT = CHAR_W'(62);

   typedef enum logic [2:0] {
      S_CONTENT,
      S_TAG,
      S_WAIT_FIN,
      S_RELEASE,
      S_ERROR
   } state_t;

   state_t              r_state;
   logic [DW-1:0]       r_depth;
   logic [CW-1:0]       r_fin_cnt;
   logic                r_char_ready;
   logic                r_elem_enable;
   logic                r_event_valid;
   logic                r_event_close;
   logic [TAG_W-1:0]    r_event_tag;
   logic                r_text_valid;
   logic [CHAR_W-1:0]   r_text_char;
   logic                r_doc_done;
   logic                r_error;
   logic [2:0]          r_error_code;
   logic [TAG_W-1:0]    r_stack [DEPTH];

   logic                w_accept;
   logic                w_fin;
   logic                w_overflow;
   logic                w_underflow;
   logic                w_mismatch;
   logic                w_err;
   logic [2:0]          w_err_code;
   logic                w_push;
   logic                w_pop;
   logic [AW-1:0]       w_top_idx;
   logic [TAG_W-1:0]    w_top;
   logic [TAG_W-1:0]    w_close_tag;

   assign w_accept  = char_valid & r_char_ready;
   assign w_top_idx = AW'(r_depth - DW'(1));
   assign w_top     = (r_depth != '0) ? r_stack[w_top_idx] : '0;

   always_comb begin
      w_fin       = (r_state == S_WAIT_FIN) && elem_finished;
      w_overflow  = w_fin && !elem_closing && (r_depth == DW'(DEPTH));
      w_underflow = w_fin && elem_closing && (r_depth == '0);
`ifdef DOC_TAG_MATCH_CHECK_EN
      w_mismatch  = w_fin && elem_closing && (r_depth != '0) && (w_top != elem_tag);
      w_close_tag = elem_tag;
`else
      w_mismatch  = 1'b0;
      w_close_tag = w_top;
`endif
      w_err       = w_overflow | w_underflow | w_mismatch;
      w_err_code  = 3'd0;
      if (w_overflow)
         w_err_code = 3'd1;
      else if (w_underflow)
         w_err_code = 3'd2;
      else if (w_mismatch)
         w_err_code = 3'd3;
      w_push      = w_fin && !elem_closing && !w_err;
      w_pop       = w_fin && elem_closing && !w_err;
   end

   // One register per stack level; only the slot at the current depth is written on a push.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
         always_ff @(posedge clock) begin
            if (reset)
               r_stack[gi] <= '0;
            else if (w_push && (r_depth == DW'(gi)))
               r_stack[gi] <= elem_tag;
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_CONTENT;
         r_depth       <= '0;
         r_fin_cnt     <= '0;
         r_char_ready  <= 1'b1;
         r_elem_enable <= 1'b0;
         r_event_valid <= 1'b0;
         r_event_close <= 1'b0;
         r_event_tag   <= '0;
         r_text_valid  <= 1'b0;
         r_text_char   <= '0;
         r_doc_done    <= 1'b0;
         r_error       <= 1'b0;
         r_error_code  <= 3'd0;
      end else begin
         r_event_valid <= 1'b0;
         r_text_valid  <= 1'b0;
         r_doc_done    <= 1'b0;
         case (r_state)
            S_CONTENT: begin
               if (w_accept) begin
                  if (char == CH_LT) begin
                     r_state       <= S_TAG;
                     r_elem_enable <= 1'b1;
                  end else if (r_depth != '0) begin
                     r_text_valid <= 1'b1;
                     r_text_char  <= char;
                  end
               end
            end
            S_TAG: begin
               if (w_accept && (char == CH_GT)) begin
                  r_state      <= S_WAIT_FIN;
                  r_char_ready <= 1'b0;
                  r_fin_cnt    <= '0;
               end
            end
            S_WAIT_FIN: begin
               if (w_fin) begin
                  r_elem_enable <= 1'b0;
                  if (w_err) begin
                     r_state      <= S_ERROR;
                     r_char_ready <= 1'b1;
                     r_error      <= 1'b1;
                     r_error_code <= w_err_code;
                  end else begin
                     r_state       <= S_RELEASE;
                     r_event_valid <= 1'b1;
                     r_event_close <= elem_closing;
                     if (w_push) begin
                        r_event_tag <= elem_tag;
                        r_depth     <= r_depth + DW'(1);
                     end else begin
                        r_event_tag <= w_close_tag;
                        r_depth     <= r_depth - DW'(1);
                        r_doc_done  <= (r_depth == DW'(1));
                     end
                  end
               end else if (r_fin_cnt == CW'(FIN_TIMEOUT - 1)) begin
                  r_state       <= S_ERROR;
                  r_elem_enable <= 1'b0;
                  r_char_ready  <= 1'b1;
                  r_error       <= 1'b1;
                  r_error_code  <= 3'd4;
               end else begin
                  r_fin_cnt <= r_fin_cnt + CW'(1);
               end
            end
            S_RELEASE: begin
               r_state      <= S_CONTENT;
               r_char_ready <= 1'b1;
               r_fin_cnt    <= '0;
            end
            S_ERROR: begin
               r_char_ready  <= 1'b1;
               r_elem_enable <= 1'b0;
            end
            default: begin
               r_state       <= S_CONTENT;
               r_char_ready  <= 1'b1;
               r_elem_enable <= 1'b0;
            end
         endcase
      end
   end

   // Idle TAG cycles feed NUL so the parser does not advance.
   assign elem_char   = ((r_state == S_TAG) && char_valid) ? char : '0;
   assign char_ready  = r_char_ready;
   assign elem_enable = r_elem_enable;
   assign event_valid = r_event_valid;
   assign event_close = r_event_close;
   assign event_tag   = r_event_tag;
   assign text_valid  = r_text_valid;
   assign text_char   = r_text_char;
   assign depth       = r_depth;
   assign doc_done    = r_doc_done;
   assign error       = r_error;
   assign error_code  = r_error_code;

endmodule
